// File: rtl/pcie2_x1_rx_pkg.sv
// Shared types for the x1 PIPE RX CTC sequencer.
// State encoding and timer width.
package pcie2_x1_rx_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RECOVER = 3'd4
  } seq_st_e;

endpackage

// File: rtl/pcie2_x1_sync2.sv
// Generic 2-flop synchroniser.
// RST_VAL selects the value both flops take in reset.
module pcie2_x1_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {2{RST_VAL}};
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pcie2_x1_rx_ctc_seq.sv
// x1 PIPE RX CTC sequencer: elastic-buffer reset FSM and RxValid qualifier.
// Define CTC_ERR_CNT_EN to build the saturating CTC error counter.
module pcie2_x1_rx_ctc_seq
  import pcie2_x1_rx_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned VALID_DLY  = 21,
  parameter int unsigned DRAIN_CYC  = 8,
  parameter int unsigned RECOV_CYC  = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             ff_rx_fclk_chx,
  input  logic             RESET_n,
  input  logic             pcs_wait_done,
  input  logic             Rate_in,
  input  logic             rx_ei_in,
  input  logic             RxValid_in,
  input  logic             ctc_uflow,
  input  logic             ctc_oflow,
  output logic             ctc_rst_n,
  output logic             rx_valid_qual,
  output logic             rx_ready,
  output logic [2:0]       seq_state,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(DRAIN_CYC - 1);
  localparam logic [TMR_W-1:0] RECOV_LD  = TMR_W'(RECOV_CYC - 1);

  logic done_s, rate_s, ei_s;
  logic uflow_s, oflow_s;
  logic err_s, rate_chg;

  pcie2_x1_sync2 #(.RST_VAL(1'b0)) u_sync_done (
    .clk_i (ff_rx_fclk_chx),
    .rst_ni(RESET_n),
    .d_i   (pcs_wait_done),
    .q_o   (done_s)
  );

  pcie2_x1_sync2 #(.RST_VAL(1'b1)) u_sync_rate (
    .clk_i (ff_rx_fclk_chx),
    .rst_ni(RESET_n),
    .d_i   (Rate_in),
    .q_o   (rate_s)
  );

  pcie2_x1_sync2 #(.RST_VAL(1'b1)) u_sync_ei (
    .clk_i (ff_rx_fclk_chx),
    .rst_ni(RESET_n),
    .d_i   (rx_ei_in),
    .q_o   (ei_s)
  );

  pcie2_x1_sync2 #(.RST_VAL(1'b0)) u_sync_uflow (
    .clk_i (ff_rx_fclk_chx),
    .rst_ni(RESET_n),
    .d_i   (ctc_uflow),
    .q_o   (uflow_s)
  );

  pcie2_x1_sync2 #(.RST_VAL(1'b0)) u_sync_oflow (
    .clk_i (ff_rx_fclk_chx),
    .rst_ni(RESET_n),
    .d_i   (ctc_oflow),
    .q_o   (oflow_s)
  );

  seq_st_e              state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 rate_q;
  logic                 ctc_rst_n_q;
  logic                 rx_ready_q;
  logic                 rx_valid_q;
  logic [VALID_DLY-1:0] valid_pipe_q, valid_pipe_d;

  assign err_s    = uflow_s | oflow_s;
  assign rate_chg = rate_s ^ rate_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (done_s && rate_s) begin
          state_d = ST_RUN;
        end else if (done_s && !ei_s) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (ei_s || !done_s) state_d = ST_IDLE;
        else if (tmr_q == '0) state_d = ST_RUN;
        else tmr_d = tmr_q - 1'b1;
      end
      ST_RUN: begin
        if (!done_s) begin
          state_d = ST_IDLE;
        end else if (rate_chg) begin
          state_d = ST_RECOVER;
          tmr_d   = RECOV_LD;
        end else if (ei_s) begin
          state_d = ST_DRAIN;
          tmr_d   = DRAIN_LD;
        end else if (err_s) begin
          state_d = ST_RECOVER;
          tmr_d   = RECOV_LD;
        end
      end
      ST_DRAIN: begin
        if (!done_s || tmr_q == '0) state_d = ST_IDLE;
        else tmr_d = tmr_q - 1'b1;
      end
      ST_RECOVER: begin
        // fresh trouble restarts the hold-off window
        if (rate_chg || err_s) begin
          tmr_d = RECOV_LD;
        end else if (tmr_q == '0) begin
          if (rate_s && done_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_SETTLE;
            tmr_d   = SETTLE_LD;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  assign valid_pipe_d =
    VALID_DLY'({valid_pipe_q, RxValid_in & done_s});

  always_ff @(posedge ff_rx_fclk_chx or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      rate_q       <= 1'b1;
      ctc_rst_n_q  <= 1'b0;
      rx_ready_q   <= 1'b0;
      rx_valid_q   <= 1'b0;
      valid_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      rate_q      <= rate_s;
      ctc_rst_n_q <= (state_d == ST_RUN) ||
                     (state_d == ST_DRAIN);
      rx_ready_q  <= (state_d == ST_RUN);
      rx_valid_q  <= valid_pipe_q[VALID_DLY-1] &
                     (state_d == ST_RUN);
      // lock history is dropped while the buffer is held in reset
      valid_pipe_q <= ctc_rst_n_q ? valid_pipe_d : '0;
    end
  end

`ifdef CTC_ERR_CNT_EN
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;

  assign cnt_inc = err_s && !err_q && !(&cnt_q) &&
                   ((state_q == ST_RUN) ||
                    (state_q == ST_DRAIN));

  always_ff @(posedge ff_rx_fclk_chx or negedge RESET_n) begin
    if (!RESET_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_s;
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign ctc_rst_n     = ctc_rst_n_q;
  assign rx_ready      = rx_ready_q;
  assign rx_valid_qual = rx_valid_q;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_pcie2_x1_rx_ctc_seq.sv
// Bench for the x1 RX CTC sequencer: cycle model plus directed scenarios.
// Honours CTC_ERR_CNT_EN for the error-count expectations.
module tb_pcie2_x1_rx_ctc_seq;

  localparam int SETTLE_CYC = 16;
  localparam int VALID_DLY  = 21;
  localparam int DRAIN_CYC  = 8;
  localparam int RECOV_CYC  = 4;
  localparam int CNT_W      = 8;
`ifdef CTC_ERR_CNT_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  logic rate = 1'b0;
  logic ei = 1'b1;
  logic rxv = 1'b0;
  logic uf = 1'b0;
  logic of = 1'b0;

  logic             ctc_rst_n;
  logic             rx_valid_qual;
  logic             rx_ready;
  logic [2:0]       seq_state;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  pcie2_x1_rx_ctc_seq #(
    .SETTLE_CYC(SETTLE_CYC),
    .VALID_DLY (VALID_DLY),
    .DRAIN_CYC (DRAIN_CYC),
    .RECOV_CYC (RECOV_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .ff_rx_fclk_chx(clk),
    .RESET_n       (rst_n),
    .pcs_wait_done (done),
    .Rate_in       (rate),
    .rx_ei_in      (ei),
    .RxValid_in    (rxv),
    .ctc_uflow     (uf),
    .ctc_oflow     (of),
    .ctc_rst_n     (ctc_rst_n),
    .rx_valid_qual (rx_valid_qual),
    .rx_ready      (rx_ready),
    .seq_state     (seq_state),
    .err_cnt       (err_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int  m_st, m_age, m_cnt, m_open;
  bit  m_rstn, m_rdy, m_q;
  bit  sd[2], sr[2], se[2], su[2], so[2];
  bit  m_rq, m_errp;
  bit  vq[$];

  task automatic model_step();
    bit ds, rs, es, errs, rchg, reload, smp, qual;
    int nst;
    ds = sd[1]; rs = sr[1]; es = se[1];
    errs = su[1] | so[1];
    rchg = (sr[1] != m_rq);
    nst = m_st;
    reload = 1'b0;
    case (m_st)
      0: if (ds && rs) nst = 2;
         else if (ds && !es) nst = 1;
      1: if (es || !ds) nst = 0;
         else if (m_age == SETTLE_CYC - 1) nst = 2;
      2: if (!ds) nst = 0;
         else if (rchg) nst = 4;
         else if (es) nst = 3;
         else if (errs) nst = 4;
      3: if (!ds || m_age == DRAIN_CYC - 1) nst = 0;
      4: if (rchg || errs) reload = 1'b1;
         else if (m_age == RECOV_CYC - 1) nst = (rs && ds) ? 2 : 1;
      default: nst = 0;
    endcase
    if (ERR_ON == 1 && (m_st == 2 || m_st == 3) &&
        errs && !m_errp && m_cnt < (1 << CNT_W) - 1)
      m_cnt++;
    m_errp = errs;
    if (nst != m_st || reload) m_age = 0;
    else m_age++;
    // qualified valid = lock seen VALID_DLY+1 edges ago, unbroken by reset
    smp = rxv & ds;
    qual = (vq.size() == VALID_DLY) && vq[0] &&
           (m_open >= VALID_DLY) && (nst == 2);
    if (m_rstn) m_open++;
    else m_open = 0;
    vq.push_back(smp);
    if (vq.size() > VALID_DLY) void'(vq.pop_front());
    m_q = qual;
    m_rstn = (nst == 2) || (nst == 3);
    m_rdy = (nst == 2);
    m_st = nst;
    m_rq = sr[1];
    sd[1] = sd[0]; sd[0] = done;
    sr[1] = sr[0]; sr[0] = rate;
    se[1] = se[0]; se[0] = ei;
    su[1] = su[0]; su[0] = uf;
    so[1] = so[0]; so[0] = of;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_age = 0; m_cnt = 0; m_open = 0;
      m_rstn = 0; m_rdy = 0; m_q = 0;
      sd = '{0, 0}; sr = '{1, 1}; se = '{1, 1};
      su = '{0, 0}; so = '{0, 0};
      m_rq = 1; m_errp = 0;
      vq.delete();
    end else begin
      model_step();
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      n_chk++;
      if (seq_state == m_st[2:0] && ctc_rst_n == m_rstn &&
          rx_ready == m_rdy && rx_valid_qual == m_q &&
          int'(err_cnt) == m_cnt) begin
        n_pass++;
      end else begin
        $display("FAIL cycle t=%0t: got st=%0d rstn=%0d rdy=%0d q=%0d cnt=%0d expected st=%0d rstn=%0d rdy=%0d q=%0d cnt=%0d",
                 $time, seq_state, ctc_rst_n, rx_ready, rx_valid_qual,
                 err_cnt, m_st, m_rstn, m_rdy, m_q, m_cnt);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic phase(input int st, output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (int'(seq_state) == st) n++;
      else if (n > 0) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic edges_to_rstn(output int t);
    t = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (ctc_rst_n) begin
        t = i;
        break;
      end
    end
  endtask

  task automatic wait_run(input string nm);
    int ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (seq_state == 3'd2) begin
        ok = 1;
        break;
      end
    end
    chk(nm, ok, 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_rstn"}, ctc_rst_n, 0);
    chk({nm, "_qual"}, rx_valid_qual, 0);
    chk({nm, "_rdy"}, rx_ready, 0);
    chk({nm, "_state"}, seq_state, 0);
    chk({nm, "_cnt"}, err_cnt, 0);
  endtask

  initial begin
    int t, n;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");

    // release: 2 sync + 1 entry + 16 settle
    rst_n = 1'b1;
    @(negedge clk);
    done = 1'b1; ei = 1'b0; rate = 1'b0;
    edges_to_rstn(t);
    chk("release_lat", t, 19);
    chk("release_state", seq_state, 2);

    // single RxValid pulse -> VALID_DLY+1 edges to qual
    repeat (30) @(negedge clk);
    rxv = 1'b1;
    @(negedge clk);
    rxv = 1'b0;
    t = -1;
    for (int i = 2; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (rx_valid_qual) begin
        t = i;
        break;
      end
    end
    chk("valid_lat", t, VALID_DLY + 1);
    @(posedge clk);
    #1;
    chk("valid_width", rx_valid_qual, 0);

    // EI drain with lock held
    @(negedge clk);
    rxv = 1'b1;
    repeat (25) @(negedge clk);
    chk("valid_hold", rx_valid_qual, 1);
    ei = 1'b1;
    phase(2, n);
    t = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (seq_state == 3'd3) begin
        n++;
        if (!ctc_rst_n || rx_valid_qual) t++;
      end
      @(posedge clk);
      #1;
      if (n > 0 && seq_state != 3'd3) break;
    end
    chk("drain_len", n, DRAIN_CYC);
    chk("drain_outs", t, 0);
    chk("drain_exit", seq_state, 0);
    chk("drain_exit_rstn", ctc_rst_n, 0);

    // overflow pulse -> recover 4, settle 16, run
    @(negedge clk);
    ei = 1'b0; rxv = 1'b0;
    wait_run("err_prep");
    @(negedge clk);
    of = 1'b1;
    @(negedge clk);
    of = 1'b0;
    phase(4, n);
    chk("recov_len", n, RECOV_CYC);
    phase(1, n);
    chk("recov_settle", n, SETTLE_CYC);
    chk("recov_run", seq_state, 2);
    chk("recov_cnt", err_cnt, ERR_ON);

    // rate 0->1 with EI raised: recover then gen2 bypass to run
    @(negedge clk);
    rate = 1'b1; ei = 1'b1;
    phase(4, n);
    chk("rate_recov_len", n, RECOV_CYC);
    chk("rate_bypass_run", seq_state, 2);
    chk("rate_bypass_rstn", ctc_rst_n, 1);
    @(posedge clk);
    #1;
    chk("rate_then_drain", seq_state, 3);

    // async reset in DRAIN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    rate = 1'b0; ei = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    edges_to_rstn(t);
    chk("mid_rst_release", t, 19);

    // simultaneous rate change and underflow: one recover, one count
    repeat (5) @(negedge clk);
    rate = 1'b1; uf = 1'b1;
    @(negedge clk);
    uf = 1'b0;
    phase(4, n);
    chk("dual_recov_len", n, RECOV_CYC);
    chk("dual_run", seq_state, 2);
    chk("dual_cnt", err_cnt, ERR_ON);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
